dmi_responder: RTL and testbench

- Target-side endpoint of the DMI request/response channel driven by `dmi_jtag`. Accepts one DMI request at a time and performs the access on a small lock-gated register window plus one status register.
- Returns exactly one DMI response per accepted request, with backpressure on both channels.
- Sits between the JTAG DMI initiator and debug-visible data registers; the unlock input comes from the JTAG hash-unlock logic.

---
 rtl/dmi_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmi_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_responder.sv
// dmi_responder: target-side endpoint of the DMI request/response channel.
// Accepts one request at a time, performs it on a lock-gated window of
// 32-bit data registers plus one status register, and returns exactly one
// response per accepted request. Inputs other than valid are ignored
// outside IDLE because the request is captured at the handshake.
module dmi_responder #(
    parameter int         NumRegs    = 12,
    parameter logic [6:0] BaseAddr   = 7'h04,
    parameter logic [6:0] StatusAddr = 7'h11
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   jtag_unlock_i,
    input  logic                   dmi_req_valid_i,
    output logic                   dmi_req_ready_o,
    input  logic [6:0]             dmi_req_addr_i,
    input  logic [1:0]             dmi_req_op_i,
    input  logic [31:0]            dmi_req_data_i,
    output logic                   dmi_resp_valid_o,
    input  logic                   dmi_resp_ready_i,
    output logic [31:0]            dmi_resp_data_o,
    output logic [1:0]             dmi_resp_o,
    output logic [NumRegs*32-1:0]  data_regs_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

    // Window bounds computed in 8 bits so BaseAddr+NumRegs cannot wrap.
    localparam logic [7:0] BASE_EXT  = {1'b0, BaseAddr};
    localparam logic [7:0] NUM_EXT   = 8'(NumRegs);
    localparam logic [4:0] NUM_REGS5 = 5'(NumRegs);

    logic [1:0]                  state_r;
    logic                        req_ready_r;
    logic                        resp_valid_r;
    logic [31:0]                 resp_data_r;
    logic [1:0]                  resp_r;
    logic [6:0]                  addr_r;
    logic [1:0]                  op_r;
    logic [31:0]                 wdata_r;
    logic [7:0]                  err_cnt_r;
    logic [NumRegs-1:0][31:0]    data_regs_r;

    logic [7:0]                  addr_ext_s;
    logic                        in_window_s;
    logic                        is_status_s;
    logic [3:0]                  idx_s;
    logic [31:0]                 status_s;
    logic [1:0]                  resp_code_s;
    logic [31:0]                 resp_data_s;
    logic                        wr_en_s;
    logic                        clr_s;
    logic                        inc_s;

    assign addr_ext_s  = {1'b0, addr_r};
    assign in_window_s = (addr_ext_s >= BASE_EXT) && (addr_ext_s < (BASE_EXT + NUM_EXT));
    assign is_status_s = (addr_r == StatusAddr);
    assign idx_s       = 4'(addr_ext_s - BASE_EXT);
    // Unlock is sampled live during ACCESS, not at request acceptance.
    assign status_s    = {11'h000, NUM_REGS5, err_cnt_r, 7'h00, jtag_unlock_i};

    // Decode the captured request while in ACCESS and form the response.
    always_comb begin
        resp_code_s = RESP_OK;
        resp_data_s = 32'h0000_0000;
        wr_en_s     = 1'b0;
        clr_s       = 1'b0;
        if (state_r == ST_ACCESS) begin
            case (op_r)
                OP_NOP: begin
                    resp_code_s = RESP_OK;
                end
                OP_READ: begin
                    if (in_window_s) begin
                        if (jtag_unlock_i) begin
                            resp_data_s = data_regs_r[idx_s];
                        end else begin
                            resp_code_s = RESP_FAIL;
                        end
                    end else if (is_status_s) begin
                        resp_data_s = status_s;
                    end else begin
                        resp_code_s = RESP_FAIL;
                    end
                end
                OP_WRITE: begin
                    if (in_window_s) begin
                        if (jtag_unlock_i) begin
                            wr_en_s = 1'b1;
                        end else begin
                            resp_code_s = RESP_FAIL;
                        end
                    end else if (is_status_s) begin
                        if (jtag_unlock_i) begin
                            clr_s = wdata_r[31];
                        end else begin
                            resp_code_s = RESP_FAIL;
                        end
                    end else begin
                        resp_code_s = RESP_FAIL;
                    end
                end
                default: begin
                    resp_code_s = RESP_FAIL;
                end
            endcase
        end else begin
            resp_code_s = RESP_OK;
        end
    end

    assign inc_s = (state_r == ST_ACCESS) && (resp_code_s == RESP_FAIL);

    // Request/response handshake FSM with registered channel outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            resp_r       <= RESP_OK;
            addr_r       <= 7'h00;
            op_r         <= OP_NOP;
            wdata_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dmi_req_valid_i && req_ready_r) begin
                        addr_r      <= dmi_req_addr_i;
                        op_r        <= dmi_req_op_i;
                        wdata_r     <= dmi_req_data_i;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    resp_data_r  <= resp_data_s;
                    resp_r       <= resp_code_s;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (dmi_resp_ready_i) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Data register window: written only at the end of an unlocked ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_regs_r <= {(NumRegs*32){1'b0}};
        end else if (wr_en_s) begin
            data_regs_r[idx_s] <= wdata_r;
        end else begin
            data_regs_r <= data_regs_r;
        end
    end

    // Saturating error counter; a status clear wins over an increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r <= 8'h00;
        end else if (clr_s) begin
            err_cnt_r <= 8'h00;
        end else if (inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign dmi_req_ready_o  = req_ready_r;
    assign dmi_resp_valid_o = resp_valid_r;
    assign dmi_resp_data_o  = resp_data_r;
    assign dmi_resp_o       = resp_r;
    assign data_regs_o      = data_regs_r;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed testbench for dmi_responder (NumRegs=12, BaseAddr=0x04, StatusAddr=0x11).
module tb_dmi_responder;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          jtag_unlock_i = 1'b0;
    logic          dmi_req_valid_i = 1'b0;
    logic          dmi_req_ready_o;
    logic [6:0]    dmi_req_addr_i = 7'h00;
    logic [1:0]    dmi_req_op_i = 2'd0;
    logic [31:0]   dmi_req_data_i = 32'h0;
    logic          dmi_resp_valid_o;
    logic          dmi_resp_ready_i = 1'b0;
    logic [31:0]   dmi_resp_data_o;
    logic [1:0]    dmi_resp_o;
    logic [383:0]  data_regs_o;

    int checks = 0;
    int errors = 0;

    dmi_responder dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .jtag_unlock_i    (jtag_unlock_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_req_addr_i   (dmi_req_addr_i),
        .dmi_req_op_i     (dmi_req_op_i),
        .dmi_req_data_i   (dmi_req_data_i),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .dmi_resp_data_o  (dmi_resp_data_o),
        .dmi_resp_o       (dmi_resp_o),
        .data_regs_o      (data_regs_o)
    );

    always #5 clk_i = ~clk_i;

    // Issue one request and collect its response. lat = clock edges after the
    // handshake edge until resp_valid is seen (1 means valid in cycle N+2).
    task automatic do_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                          output logic [1:0] r, output logic [31:0] rd, output int lat);
        int n;
        n = 0;
        while (!dmi_req_ready_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!dmi_req_ready_o) begin
            $display("FAIL req_ready_timeout actual=0 required=1");
            errors++;
        end
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = a;
        dmi_req_op_i    = op;
        dmi_req_data_i  = d;
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
        lat = 0;
        while (!dmi_resp_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!dmi_resp_valid_o) begin
            $display("FAIL resp_valid_timeout actual=0 required=1");
            errors++;
        end
        r  = dmi_resp_o;
        rd = dmi_resp_data_o;
        dmi_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (dmi_req_ready_o !== 1'b1) begin
            $display("FAIL reset_req_ready actual=%0b required=1", dmi_req_ready_o); errors++;
        end
        checks++;
        if (dmi_resp_valid_o !== 1'b0 || dmi_resp_data_o !== 32'h0 || dmi_resp_o !== 2'd0) begin
            $display("FAIL reset_resp actual=%0b/%h/%0d required=0/00000000/0",
                     dmi_resp_valid_o, dmi_resp_data_o, dmi_resp_o); errors++;
        end
        checks++;
        if (data_regs_o !== 384'h0) begin
            $display("FAIL reset_regs actual=%h required=0", data_regs_o); errors++;
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_unlocked_rw();
        logic [1:0] r; logic [31:0] rd; int lat;
        jtag_unlock_i = 1'b1;
        do_req(7'h04, 2'd2, 32'hDEADBEEF, r, rd, lat);
        checks++;
        if (r !== 2'd0 || rd !== 32'h0 || lat !== 1) begin
            $display("FAIL unl_write actual=%0d/%h/lat%0d required=0/00000000/lat1", r, rd, lat); errors++;
        end
        checks++;
        if (data_regs_o[31:0] !== 32'hDEADBEEF) begin
            $display("FAIL unl_write_reg actual=%h required=deadbeef", data_regs_o[31:0]); errors++;
        end
        do_req(7'h04, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd0 || rd !== 32'hDEADBEEF || lat !== 1) begin
            $display("FAIL unl_read actual=%0d/%h/lat%0d required=0/deadbeef/lat1", r, rd, lat); errors++;
        end
    endtask

    task automatic test_locked();
        logic [1:0] r; logic [31:0] rd; int lat;
        jtag_unlock_i = 1'b0;
        do_req(7'h05, 2'd2, 32'h12345678, r, rd, lat);
        checks++;
        if (r !== 2'd2 || rd !== 32'h0) begin
            $display("FAIL lock_write actual=%0d/%h required=2/00000000", r, rd); errors++;
        end
        do_req(7'h05, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd2 || rd !== 32'h0) begin
            $display("FAIL lock_read actual=%0d/%h required=2/00000000", r, rd); errors++;
        end
        checks++;
        if (data_regs_o[63:32] !== 32'h0) begin
            $display("FAIL lock_reg actual=%h required=00000000", data_regs_o[63:32]); errors++;
        end
        do_req(7'h11, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd0 || rd !== 32'h000C0200) begin
            $display("FAIL lock_status actual=%0d/%h required=0/000c0200", r, rd); errors++;
        end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [31:0] rd; int lat;
        do_req(7'h7F, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd2 || rd !== 32'h0) begin
            $display("FAIL unmapped actual=%0d/%h required=2/00000000", r, rd); errors++;
        end
        do_req(7'h04, 2'd3, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd2 || rd !== 32'h0) begin
            $display("FAIL op3 actual=%0d/%h required=2/00000000", r, rd); errors++;
        end
        do_req(7'h04, 2'd0, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd0 || rd !== 32'h0) begin
            $display("FAIL nop actual=%0d/%h required=0/00000000", r, rd); errors++;
        end
        for (int i = 0; i < 300; i++) begin
            do_req(7'h7F, 2'd1, 32'h0, r, rd, lat);
        end
        do_req(7'h11, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (rd !== 32'h000CFF00) begin
            $display("FAIL err_saturate actual=%h required=000cff00", rd); errors++;
        end
        jtag_unlock_i = 1'b1;
        do_req(7'h11, 2'd2, 32'h00000000, r, rd, lat);
        checks++;
        if (r !== 2'd0) begin
            $display("FAIL status_wr_noclr_resp actual=%0d required=0", r); errors++;
        end
        do_req(7'h11, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (rd !== 32'h000CFF01) begin
            $display("FAIL status_noclr actual=%h required=000cff01", rd); errors++;
        end
        do_req(7'h11, 2'd2, 32'h80000000, r, rd, lat);
        checks++;
        if (r !== 2'd0) begin
            $display("FAIL status_clr_resp actual=%0d required=0", r); errors++;
        end
        do_req(7'h11, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (rd !== 32'h000C0001) begin
            $display("FAIL status_cleared actual=%h required=000c0001", rd); errors++;
        end
    endtask

    task automatic test_boundaries();
        logic [1:0] r; logic [31:0] rd; int lat;
        do_req(7'h0F, 2'd2, 32'h0F0F1234, r, rd, lat);
        checks++;
        if (r !== 2'd0 || data_regs_o[383:352] !== 32'h0F0F1234) begin
            $display("FAIL last_reg_write actual=%0d/%h required=0/0f0f1234", r, data_regs_o[383:352]); errors++;
        end
        do_req(7'h10, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (r !== 2'd2) begin
            $display("FAIL past_window actual=%0d required=2", r); errors++;
        end
        do_req(7'h03, 2'd2, 32'h11111111, r, rd, lat);
        checks++;
        if (r !== 2'd2) begin
            $display("FAIL below_window actual=%0d required=2", r); errors++;
        end
        do_req(7'h11, 2'd1, 32'h0, r, rd, lat);
        checks++;
        if (rd !== 32'h000C0201) begin
            $display("FAIL boundary_status actual=%h required=000c0201", rd); errors++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        jtag_unlock_i   = 1'b1;
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = 7'h04;
        dmi_req_op_i    = 2'd1;
        @(posedge clk_i); #1;
        // Keep a second request pending on the bus throughout.
        dmi_req_addr_i  = 7'h0F;
        n = 0;
        while (!dmi_resp_valid_o && n < 20) begin
            @(posedge clk_i); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dmi_resp_valid_o !== 1'b1 || dmi_resp_data_o !== 32'hDEADBEEF || dmi_req_ready_o !== 1'b0) begin
                $display("FAIL bp_hold%0d actual=%0b/%h/%0b required=1/deadbeef/0",
                         i, dmi_resp_valid_o, dmi_resp_data_o, dmi_req_ready_o); errors++;
            end
            @(posedge clk_i); #1;
        end
        dmi_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_resp_ready_i = 1'b0;
        checks++;
        if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1) begin
            $display("FAIL bp_after_hs actual=%0b/%0b required=0/1", dmi_resp_valid_o, dmi_req_ready_o); errors++;
        end
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
        checks++;
        if (dmi_req_ready_o !== 1'b0) begin
            $display("FAIL bp_accept actual=%0b required=0", dmi_req_ready_o); errors++;
        end
        @(posedge clk_i); #1;
        checks++;
        if (dmi_resp_valid_o !== 1'b1 || dmi_resp_data_o !== 32'h0F0F1234) begin
            $display("FAIL bp_second actual=%0b/%h required=1/0f0f1234", dmi_resp_valid_o, dmi_resp_data_o); errors++;
        end
        dmi_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_resp_ready_i = 1'b0;
    endtask

    task automatic test_unlock_drop();
        jtag_unlock_i   = 1'b1;
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = 7'h07;
        dmi_req_op_i    = 2'd2;
        dmi_req_data_i  = 32'h55AA55AA;
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
        jtag_unlock_i   = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (dmi_resp_valid_o !== 1'b1 || dmi_resp_o !== 2'd2) begin
            $display("FAIL unlock_drop_resp actual=%0b/%0d required=1/2", dmi_resp_valid_o, dmi_resp_o); errors++;
        end
        checks++;
        if (data_regs_o[127:96] !== 32'h0) begin
            $display("FAIL unlock_drop_reg actual=%h required=00000000", data_regs_o[127:96]); errors++;
        end
        dmi_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_resp_ready_i = 1'b0;
        jtag_unlock_i    = 1'b1;
    endtask

    task automatic test_reset_mid();
        jtag_unlock_i   = 1'b1;
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = 7'h06;
        dmi_req_op_i    = 2'd2;
        dmi_req_data_i  = 32'hA5A5A5A5;
        @(posedge clk_i); #1;
        dmi_req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if (dmi_resp_valid_o !== 1'b0 || dmi_req_ready_o !== 1'b1) begin
            $display("FAIL rst_mid_ctrl actual=%0b/%0b required=0/1", dmi_resp_valid_o, dmi_req_ready_o); errors++;
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (data_regs_o[95:64] !== 32'h0 || dmi_resp_valid_o !== 1'b0) begin
            $display("FAIL rst_mid_reg actual=%h/%0b required=00000000/0", data_regs_o[95:64], dmi_resp_valid_o); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_unlocked_rw();
        test_locked();
        test_errors();
        test_boundaries();
        test_backpressure();
        test_unlock_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
